// File: rtl/rbzero_spi_master_pkg.sv
// Package for the rbzero SPI master: state enum and width helper.
package rbzero_spi_master_pkg;
  `include "rbzero_spi_defs.vh"

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    HIGH  = ST_HIGH,
    LOW   = ST_LOW,
    GAP   = ST_GAP
  } spi_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rbzero_spi_master_if.sv
// Request/SPI bundle for rbzero_spi_master. The master modport is the
// block itself; the slave modport is the requester/observer side.
interface rbzero_spi_master_if #(
  parameter int MAX_BITS = 96,
  parameter int LEN_W    = 7
);
  logic                i_valid;
  logic                o_ready;
  logic [LEN_W-1:0]    i_len;
  logic [MAX_BITS-1:0] i_data;
  logic                o_busy;
  logic                o_done;
  logic                o_csb;
  logic                o_sclk;
  logic                o_mosi;

  modport master (
    input  i_valid, i_len, i_data,
    output o_ready, o_busy, o_done, o_csb, o_sclk, o_mosi
  );

  modport slave (
    output i_valid, i_len, i_data,
    input  o_ready, o_busy, o_done, o_csb, o_sclk, o_mosi
  );
endinterface

// File: rtl/rbzero_spi_defs.vh
// Shared constants for the rbzero SPI master: FSM state codes and the
// frame lengths used by rbzero's vector and register slaves.
`ifndef RBZERO_SPI_DEFS_VH
`define RBZERO_SPI_DEFS_VH

localparam logic [2:0] ST_IDLE  = 3'd0;
localparam logic [2:0] ST_SETUP = 3'd1;
localparam logic [2:0] ST_HIGH  = 3'd2;
localparam logic [2:0] ST_LOW   = 3'd3;
localparam logic [2:0] ST_GAP   = 3'd4;

// Frame lengths for the rbzero slaves (bits, sent MSB first).
localparam int RB_VEC_FRAME_BITS       = 74;
localparam int RB_REG_CMD_BITS         = 4;
localparam int RB_REG_PAYLOAD_MAX_BITS = 24;

`endif

// File: rtl/spi_half_tick.sv
// CLK_DIV-cycle half-period timer. tick pulses on the last cycle of each
// half-period; restart holds the count at the start of a period.
module spi_half_tick
  import rbzero_spi_master_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int          W    = cnt_w(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: wrap at the end of each half-period, clear on restart.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || cnt_q == LAST) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST) && !restart;
endmodule

// File: rtl/rbzero_spi_master.sv
// SPI mode-0 master for rbzero's vector/register slaves. One left-justified
// frame per valid/ready handshake, shifted out MSB first. Every SPI pin is
// driven straight from a flop.
module rbzero_spi_master
  import rbzero_spi_master_pkg::*;
#(
  parameter int MAX_BITS = 96,
  parameter int LEN_W    = 7,
  parameter int CLK_DIV  = 4,
  parameter int CS_GAP   = 4
) (
  input  logic              clk,
  input  logic              reset,
  rbzero_spi_master_if.master bus
);
  if (CLK_DIV < 2) begin : g_bad_div
    $error("rbzero_spi_master: CLK_DIV must be >= 2");
  end
  if (CS_GAP < 1) begin : g_bad_gap
    $error("rbzero_spi_master: CS_GAP must be >= 1");
  end

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BITS);
  localparam int               GW       = cnt_w(CS_GAP);
  localparam logic [GW-1:0]    GAP_LAST = GW'(CS_GAP - 1);

  spi_state_e          state_q, state_d;
  logic [MAX_BITS-1:0] sh_q, sh_d;
  logic [LEN_W-1:0]    bits_q, bits_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                csb_q, csb_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic                accept, tick;
  logic [LEN_W-1:0]    eff_len;

  assign accept  = bus.i_valid && ready_q;
  assign eff_len = (bus.i_len > MAX_LEN) ? MAX_LEN : bus.i_len;

  // Held in restart while idle so SETUP always gets a full half-period.
  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (state_q == IDLE),
    .tick    (tick)
  );

  // Next state, datapath and registered-output values.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bits_d  = bits_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        sh_d   = bus.i_data;
        bits_d = eff_len;
        if (eff_len == '0) begin
          // Empty frame: a single GAP cycle carries the done pulse, csb
          // never falls and no CS gap is inserted.
          state_d = GAP;
          gap_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = SETUP;
        end
      end
      SETUP: if (tick) state_d = HIGH;
      HIGH: if (tick) begin
        // Falling edge: advance to the next bit.
        state_d = LOW;
        sh_d    = sh_q << 1;
        bits_d  = bits_q - 1'b1;
      end
      LOW: if (tick) begin
        if (bits_q == '0) begin
          state_d = GAP;
          gap_d   = GAP_LAST;
          done_d  = 1'b1;
        end else begin
          state_d = HIGH;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    csb_d   = !(state_d inside {SETUP, HIGH, LOW});
    sclk_d  = (state_d == HIGH);
    // After the last bit shifts out the line is parked at 0.
    mosi_d  = ((state_d == SETUP) || (state_d == HIGH) ||
               (state_d == LOW && bits_d != '0)) ? sh_d[MAX_BITS-1] : 1'b0;
    ready_d = (state_d == IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bits_q  <= '0;
      gap_q   <= '0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bits_q  <= bits_d;
      gap_q   <= gap_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_busy  = !ready_q;
  assign bus.o_done  = done_q;
  assign bus.o_csb   = csb_q;
  assign bus.o_sclk  = sclk_q;
  assign bus.o_mosi  = mosi_q;
endmodule

// File: tb/tb_rbzero_spi_master.sv
// Bench for rbzero_spi_master: two instances (CLK_DIV 2 and 4) each looped
// into a mode-0 slave model behind a 3-flop synchroniser; expected frames
// are queued at accept and compared when the slave sees csb rise.
module tb_rbzero_spi_master;
  import rbzero_spi_master_pkg::*;

  localparam int MB = 16;
  localparam int LW = 5;

  typedef struct {
    int          len;
    logic [31:0] val;
    bit          skip;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rbzero_spi_master_if #(.MAX_BITS(MB), .LEN_W(LW)) ifa ();
  rbzero_spi_master_if #(.MAX_BITS(MB), .LEN_W(LW)) ifb ();

  rbzero_spi_master #(.MAX_BITS(MB), .LEN_W(LW), .CLK_DIV(2), .CS_GAP(3)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  rbzero_spi_master #(.MAX_BITS(MB), .LEN_W(LW), .CLK_DIV(4), .CS_GAP(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  bit   mon_en = 1'b0;

  int   rise_cnt[2], low_cyc[2], done_cnt[2], done_rise[2], hi_run[2], hi_min[2];
  logic prev_csb[2], prev_sclk[2];
  logic [3:0]  s_sck[2], s_csb[2], s_mo[2];
  logic [31:0] rx_v[2];
  int          rx_n[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input int s, input logic v, input int len, input logic [MB-1:0] d);
    if (s == 0) begin ifa.i_valid = v; ifa.i_len = LW'(len); ifa.i_data = d; end
    else        begin ifb.i_valid = v; ifb.i_len = LW'(len); ifb.i_data = d; end
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? ifa.o_ready : ifb.o_ready;
  endfunction

  task automatic push(input int s, input int len, input logic [MB-1:0] d);
    exp_t e;
    int   el;
    el = (len > MB) ? MB : len;
    if (el == 0) return;
    e.len  = el;
    e.val  = 32'(d >> (MB - el));
    e.skip = 1'b0;
    if (s == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Called at a negedge; returns at a negedge with ready high (or timed out).
  task automatic wait_ready(input int s, input string tag);
    int n;
    n = 0;
    while (!rdy(s) && n < 5000) begin @(negedge clk); n++; end
    check(tag, 32'(rdy(s)), 32'd1);
  endtask

  task automatic send(input int s, input int len, input logic [MB-1:0] d);
    @(negedge clk);
    drive(s, 1'b1, len, d);
    wait_ready(s, (s == 0) ? "accept_a" : "accept_b");
    @(posedge clk);
    push(s, len, d);
    @(negedge clk);
    drive(s, 1'b0, 0, '0);
  endtask

  task automatic mon_clear(input int s);
    rise_cnt[s] = 0; low_cyc[s] = 0; done_cnt[s] = 0; done_rise[s] = 0;
    hi_run[s] = 0; hi_min[s] = 1000;
  endtask

  task automatic mon_step(input int s, input logic csb, input logic sclk,
                          input logic done, input logic busy, input logic ready);
    if (!mon_en) return;
    check((s == 0) ? "busy_ready_excl_a" : "busy_ready_excl_b", 32'(busy ^ ready), 32'd1);
    if (!csb) low_cyc[s]++;
    if (sclk && !prev_sclk[s]) rise_cnt[s]++;
    if (done) done_cnt[s]++;
    if (done && csb && !prev_csb[s]) done_rise[s]++;
    if (csb) hi_run[s]++;
    else if (prev_csb[s]) begin
      if (done_cnt[s] > 0 && hi_run[s] < hi_min[s]) hi_min[s] = hi_run[s];
      hi_run[s] = 0;
    end
    prev_csb[s]  = csb;
    prev_sclk[s] = sclk;
  endtask

  task automatic slave_step(input int s, input logic csb, input logic sclk, input logic mosi);
    exp_t e;
    int   sz;
    if (!mon_en) begin
      s_sck[s] = 4'h0; s_csb[s] = 4'hF; s_mo[s] = 4'h0;
      prev_csb[s] = 1'b1; prev_sclk[s] = 1'b0;
      return;
    end
    s_sck[s] = {s_sck[s][2:0], sclk};
    s_csb[s] = {s_csb[s][2:0], csb};
    s_mo[s]  = {s_mo[s][2:0], mosi};
    if (s_csb[s][3] && !s_csb[s][2]) begin rx_v[s] = '0; rx_n[s] = 0; end
    if (!s_csb[s][2] && !s_sck[s][3] && s_sck[s][2]) begin
      rx_v[s] = {rx_v[s][30:0], s_mo[s][2]};
      rx_n[s]++;
    end
    if (!s_csb[s][3] && s_csb[s][2]) begin
      sz = (s == 0) ? sb0.size() : sb1.size();
      if (sz == 0) check((s == 0) ? "frame_expected_a" : "frame_expected_b", 32'(sz), 32'd1);
      else begin
        e = (s == 0) ? sb0.pop_front() : sb1.pop_front();
        if (!e.skip) begin
          check((s == 0) ? "rx_len_a" : "rx_len_b", 32'(rx_n[s]), 32'(e.len));
          check((s == 0) ? "rx_data_a" : "rx_data_b", rx_v[s], e.val);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, ifa.o_csb, ifa.o_sclk, ifa.o_done, ifa.o_busy, ifa.o_ready);
    mon_step(1, ifb.o_csb, ifb.o_sclk, ifb.o_done, ifb.o_busy, ifb.o_ready);
    slave_step(0, ifa.o_csb, ifa.o_sclk, ifa.o_mosi);
    slave_step(1, ifb.o_csb, ifb.o_sclk, ifb.o_mosi);
  end

  task automatic rand_run(input int s, input int nfr, input int min_gap);
    mon_clear(s);
    for (int i = 0; i < nfr; i++) begin
      int            len;
      logic [MB-1:0] d;
      len = int'($urandom_range(1, 16));
      d   = MB'($urandom);
      send(s, len, d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_ready(s, (s == 0) ? "rand_end_a" : "rand_end_b");
    repeat (10) @(negedge clk);
    check((s == 0) ? "rand_done_a" : "rand_done_b", 32'(done_cnt[s]), 32'(nfr));
    check((s == 0) ? "rand_gap_a" : "rand_gap_b", 32'(hi_min[s] >= min_gap), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    exp_t e;
    drive(0, 1'b0, 0, '0);
    drive(1, 1'b0, 0, '0);
    for (int s = 0; s < 2; s++) begin mon_clear(s); rx_v[s] = '0; rx_n[s] = 0; end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_csb",   32'(ifa.o_csb),   32'd1);
    check("rst_sclk",  32'(ifa.o_sclk),  32'd0);
    check("rst_mosi",  32'(ifa.o_mosi),  32'd0);
    check("rst_ready", 32'(ifa.o_ready), 32'd1);
    check("rst_busy",  32'(ifa.o_busy),  32'd0);
    check("rst_done",  32'(ifa.o_done),  32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // len 8, 0xA500 -> 1,0,1,0,0,1,0,1
    mon_clear(0);
    send(0, 8, 16'hA500);
    wait_ready(0, "t1_end");
    repeat (6) @(negedge clk);
    check("t1_rises",        32'(rise_cnt[0]),  32'd8);
    check("t1_csb_low",      32'(low_cyc[0]),   32'd34);
    check("t1_done_cnt",     32'(done_cnt[0]),  32'd1);
    check("t1_done_at_rise", 32'(done_rise[0]), 32'd1);

    // back-to-back with i_valid held
    mon_clear(0);
    @(negedge clk);
    drive(0, 1'b1, 4, 16'hF000);
    wait_ready(0, "t2_rdy1");
    @(posedge clk);
    push(0, 4, 16'hF000);
    @(negedge clk);
    drive(0, 1'b1, 4, 16'h1000);
    check("t2_not_ready", 32'(ifa.o_ready), 32'd0);
    wait_ready(0, "t2_rdy2");
    @(posedge clk);
    push(0, 4, 16'h1000);
    @(negedge clk);
    drive(0, 1'b0, 0, '0);
    wait_ready(0, "t2_end");
    repeat (6) @(negedge clk);
    check("t2_done_cnt", 32'(done_cnt[0]), 32'd2);
    check("t2_csb_gap",  32'(hi_min[0] >= 4), 32'd1);
    check("t2_rises",    32'(rise_cnt[0]), 32'd8);

    // zero-length frame
    mon_clear(0);
    @(negedge clk);
    drive(0, 1'b1, 0, 16'hFFFF);
    wait_ready(0, "t3_rdy");
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 0, '0);
    check("t3_done",      32'(ifa.o_done),  32'd1);
    check("t3_ready_lo",  32'(ifa.o_ready), 32'd0);
    check("t3_csb",       32'(ifa.o_csb),   32'd1);
    @(negedge clk);
    check("t3_ready_back", 32'(ifa.o_ready), 32'd1);
    check("t3_done_off",   32'(ifa.o_done),  32'd0);
    repeat (4) @(negedge clk);
    check("t3_csb_low", 32'(low_cyc[0]),  32'd0);
    check("t3_rises",   32'(rise_cnt[0]), 32'd0);
    check("t3_done_cnt", 32'(done_cnt[0]), 32'd1);

    // register command header
    send(0, RB_REG_CMD_BITS, 16'h9000);
    wait_ready(0, "t3b_end");

    // reset during bit 5 of a 16-bit frame
    mon_clear(0);
    send(0, 16, 16'hC3A5);
    n = 0;
    while (rise_cnt[0] < 5 && n < 1000) begin @(negedge clk); n++; end
    check("t4_reach_bit5", 32'(rise_cnt[0] >= 5), 32'd1);
    if (sb0.size() > 0) begin
      e = sb0[sb0.size() - 1];
      e.skip = 1'b1;
      sb0[sb0.size() - 1] = e;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_csb",   32'(ifa.o_csb),   32'd1);
    check("t4_sclk",  32'(ifa.o_sclk),  32'd0);
    check("t4_mosi",  32'(ifa.o_mosi),  32'd0);
    check("t4_ready", 32'(ifa.o_ready), 32'd1);
    repeat (8) @(negedge clk);
    check("t4_no_done", 32'(done_cnt[0]), 32'd0);
    send(0, 16, 16'h1234);
    wait_ready(0, "t4_end");

    // over-length frame clamps to MAX_BITS
    mon_clear(0);
    send(0, 20, 16'hBEEF);
    wait_ready(0, "t5_end");
    repeat (6) @(negedge clk);
    check("t5_rises", 32'(rise_cnt[0]), 32'd16);

    // random loopback on both dividers
    fork
      rand_run(0, 200, 4);
      rand_run(1, 200, 5);
    join

    repeat (10) @(negedge clk);
    check("sb_drain_a", 32'(sb0.size()), 32'd0);
    check("sb_drain_b", 32'(sb1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
